// File: rtl/mon_packet_rx_pkg.sv
// Shared definitions for the monitor data line receiver and its op decoder.
package mon_packet_rx_pkg;

  localparam int OP_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP
  } state_t;

  localparam logic [15:0] OP_C5EF = 16'hC5EF;
  localparam logic [15:0] OP_C500 = 16'hC500;
  localparam logic [7:0]  OPH_1F  = 8'h1F;
  localparam logic [7:0]  OPH_0F  = 8'h0F;
  localparam logic [7:0]  OPH_C7  = 8'hC7;
  localparam logic [7:0]  OPH_FF  = 8'hFF;

  // True when the op matches one of the codes the decoder acts on.
  function automatic logic op_is_known(input logic [OP_BITS-1:0] op);
    logic [7:0] hi;
    hi = op[15:8];
    return (op == OP_C5EF) || (op == OP_C500) || (hi == OPH_1F) ||
           (hi == OPH_0F) || (hi == OPH_C7) || (hi == OPH_FF);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for host-driven asynchronous lines.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/mon_packet_rx.sv
// Frames the synchronized monitor serial line into start/op/data/stop packets
// and presents each good packet as a parallel op/data word.
module mon_packet_rx
  import mon_packet_rx_pkg::*;
#(
  parameter int DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 si,
  input  logic                 bit_tick,
  output logic [OP_BITS-1:0]   op,
  output logic [DATA_BITS-1:0] data,
  output logic                 op_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int FRAME_BITS = OP_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic                  w_si_s;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [OP_BITS-1:0]    r_op;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_op_valid;
  logic                  r_frame_err;
  logic                  r_busy;

  bit_sync u_si_sync (
    .clk   (clk),
    .reset (reset),
    .d     (si),
    .q     (w_si_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_op        <= '0;
      r_data      <= '0;
      r_op_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_op_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (bit_tick) begin
        case (r_state)
          IDLE: begin
            // busy drops one cycle late so it covers the result strobe.
            r_busy <= w_si_s;
            if (w_si_s) begin
              r_state <= SHIFT;
              r_cnt   <= '0;
            end
          end
          SHIFT: begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_si_s};
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
              r_state <= STOP;
            end
          end
          STOP: begin
            if (!w_si_s) begin
              r_op       <= r_shift[FRAME_BITS-1 -: OP_BITS];
              r_data     <= r_shift[DATA_BITS-1:0];
              r_op_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end else if (r_state == IDLE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign op        = r_op;
  assign data      = r_data;
  assign op_valid  = r_op_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mon_packet_rx.sv
// Randomized bench for mon_packet_rx: frames are built from op/data/stop values
// and each is expected to resolve at a computed cycle with a computed result.
module tb_mon_packet_rx;

  localparam int DB = 24;
  localparam int NB = 16 + DB + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          si;
  logic          bit_tick;
  logic [15:0]   op;
  logic [DB-1:0] data;
  logic          op_valid;
  logic          frame_err;
  logic          busy;

  mon_packet_rx #(.DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .si        (si),
    .bit_tick  (bit_tick),
    .op        (op),
    .data      (data),
    .op_valid  (op_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            start_e;
    int            due_e;
    logic          err;
    logic [15:0]   op;
    logic [DB-1:0] data;
  } ev_t;

  ev_t           evq[$];
  int            checks = 0;
  int            errors = 0;
  int            edge_n = 0;
  logic          tick_d1 = 1'b0;
  logic          tick_d2 = 1'b0;
  logic [15:0]   m_op = '0;
  logic [DB-1:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Compare DUT outputs after an edge against the frame schedule.
  task automatic monitor(input logic r);
    logic exp_busy;
    if (r) begin
      evq.delete();
      m_op   = '0;
      m_data = '0;
      chk("rst_valid", {31'b0, op_valid}, 0);
      chk("rst_err",   {31'b0, frame_err}, 0);
      chk("rst_busy",  {31'b0, busy}, 0);
      chk("rst_op",    {16'b0, op}, 0);
      chk("rst_data",  32'(data), 0);
      return;
    end
    exp_busy = 1'b0;
    foreach (evq[i])
      if (evq[i].start_e <= edge_n && edge_n <= evq[i].due_e) exp_busy = 1'b1;
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    if (evq.size() > 0 && evq[0].due_e == edge_n) begin
      chk("op_valid",  {31'b0, op_valid},  {31'b0, !evq[0].err});
      chk("frame_err", {31'b0, frame_err}, {31'b0, evq[0].err});
      if (!evq[0].err) begin
        m_op   = evq[0].op;
        m_data = evq[0].data;
      end
      void'(evq.pop_front());
    end else begin
      chk("no_valid", {31'b0, op_valid}, 0);
      chk("no_err",   {31'b0, frame_err}, 0);
    end
    chk("op",   {16'b0, op}, {16'b0, m_op});
    chk("data", 32'(data), 32'(m_data));
  endtask

  // bit_tick trails si by two cycles to line up with the synchronizer output.
  task automatic step(input logic s, input logic t, input logic r);
    @(negedge clk);
    si       = s;
    reset    = r;
    bit_tick = tick_d2;
    tick_d2  = tick_d1;
    tick_d1  = t;
    @(posedge clk);
    #1;
    edge_n++;
    monitor(r);
  endtask

  task automatic idle(input int n, input bit rand_ticks);
    for (int i = 0; i < n; i++)
      step(1'b0, rand_ticks ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
  endtask

  // Send the first nbits of a frame, one bit per period cycles.
  task automatic send_frame(input logic [15:0] f_op, input logic [DB-1:0] f_data,
                            input logic stop, input int period, input int nbits);
    logic [NB-1:0] fr;
    ev_t           ev;
    fr         = {1'b1, f_op, f_data, stop};
    ev.start_e = edge_n + 3;
    ev.due_e   = edge_n + 3 + (NB - 1) * period;
    ev.err     = stop;
    ev.op      = f_op;
    ev.data    = f_data;
    evq.push_back(ev);
    for (int b = 0; b < nbits; b++)
      for (int k = 0; k < period; k++)
        step(fr[NB-1-b], k == 0, 1'b0);
  endtask

  initial begin
    si       = 1'b0;
    bit_tick = 1'b0;
    reset    = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);

    send_frame(16'hC5EF, 24'h000000, 1'b0, 4, NB);
    idle(6, 1'b0);

    send_frame(16'hC712, 24'hABCDEF, 1'b0, 1, NB);
    send_frame(16'h0F00, 24'h000001, 1'b0, 1, NB);
    idle(5, 1'b0);

    send_frame(16'h1234, 24'h555555, 1'b1, 2, NB);
    idle(6, 1'b0);

    send_frame(16'hFFFF, 24'hFFFFFF, 1'b0, 1, NB);
    idle(5, 1'b0);

    send_frame(16'h0123, 24'h456789, 1'b0, 1, 10);
    step(1'b0, 1'b0, 1'b1);
    idle(5, 1'b0);
    send_frame(16'hC500, 24'h000000, 1'b0, 3, NB);
    idle(6, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    idle(8, 1'b0);

    for (int f = 0; f < 24; f++) begin
      send_frame(16'($urandom), DB'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(1, 4), NB);
      idle($urandom_range(0, 4), 1'b1);
    end
    idle(8, 1'b0);

    chk("pending", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
